pkt_rr_arb: RTL and testbench

//  Packet-granular round-robin arbiter merging two packet FIFOs (drop-on-error

---
 rtl/pkt_rr_arb.sv | 146 ++++++++++++++
 tb/tb_pkt_rr_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rr_arb.sv
// rtl/pkt_rr_arb.sv - packet-granular round-robin arbiter merging two packet FIFOs
module pkt_rr_arb #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW+1:0] ch0_q,
  input  logic          ch0_empty,
  input  logic          ch0_pkt_avail,
  output logic          ch0_rdreq,
  input  logic [DW+1:0] ch1_q,
  input  logic          ch1_empty,
  input  logic          ch1_pkt_avail,
  output logic          ch1_rdreq,
  input  logic          dout_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          cur_ch,
  output logic          proto_err,
  output logic [15:0]   pkt_cnt0,
  output logic [15:0]   pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last_ch;     // channel granted most recently; the other wins a tie
  logic          first_word;  // next word read belongs at the start of the grant
  logic          rd_any;
  logic [DW+1:0] rd_word;
  logic          rd_sop;
  logic          rd_eop;

  // The word under consideration is the show-ahead word of whichever channel holds the grant
  always_comb begin
    rd_word = (state == GNT1) ? ch1_q : ch0_q;
    rd_sop  = rd_word[DW+1];
    rd_eop  = rd_word[DW];
    rd_any  = ch0_rdreq | ch1_rdreq;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: pick a channel with a whole packet, release after reading the eop word
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ch0_pkt_avail && (!ch1_pkt_avail || last_ch)) begin
          state_nxt = GNT0;
        end else if (ch1_pkt_avail) begin
          state_nxt = GNT1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (ch0_rdreq && rd_eop) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (ch1_rdreq && rd_eop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO read strobes: only the granted channel, only when downstream is ready and data exists
  always_comb begin
    ch0_rdreq = (state == GNT0) && dout_rdy && !ch0_empty;
    ch1_rdreq = (state == GNT1) && dout_rdy && !ch1_empty;
  end

  // Grant bookkeeping: remember who was granted and whether the grant has produced a word yet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ch    <= 1'b1;
      cur_ch     <= 1'b0;
      first_word <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == GNT0) begin
        last_ch    <= 1'b0;
        cur_ch     <= 1'b0;
        first_word <= 1'b1;
      end else if (state == IDLE && state_nxt == GNT1) begin
        last_ch    <= 1'b1;
        cur_ch     <= 1'b1;
        first_word <= 1'b1;
      end else if (rd_any) begin
        first_word <= 1'b0;
      end
    end
  end

  // Output stage: a word read this cycle is presented next cycle; data holds when nothing is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      dout_vld  <= rd_any;
      dout_sop  <= rd_any && rd_sop;
      dout_eop  <= rd_any && rd_eop;
      proto_err <= rd_any && (first_word ? !rd_sop : rd_sop);
      if (rd_any) begin
        dout <= rd_word[DW-1:0];
      end
    end
  end

  // Per-channel packet counters advance together with the eop word leaving the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= 16'd0;
      pkt_cnt1 <= 16'd0;
    end else begin
      if (ch0_rdreq && rd_eop) begin
        pkt_cnt0 <= pkt_cnt0 + 16'd1;
      end
      if (ch1_rdreq && rd_eop) begin
        pkt_cnt1 <= pkt_cnt1 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// tb/tb_pkt_rr_arb.sv - self-checking bench for pkt_rr_arb
module tb_pkt_rr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] ch0_q = '0;
  logic        ch0_empty = 1'b1;
  logic        ch0_pkt_avail = 1'b0;
  logic        ch0_rdreq;
  logic [17:0] ch1_q = '0;
  logic        ch1_empty = 1'b1;
  logic        ch1_pkt_avail = 1'b0;
  logic        ch1_rdreq;
  logic        dout_rdy = 1'b0;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic        cur_ch;
  logic        proto_err;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;

  pkt_rr_arb #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_q(ch0_q), .ch0_empty(ch0_empty), .ch0_pkt_avail(ch0_pkt_avail), .ch0_rdreq(ch0_rdreq),
    .ch1_q(ch1_q), .ch1_empty(ch1_empty), .ch1_pkt_avail(ch1_pkt_avail), .ch1_rdreq(ch1_rdreq),
    .dout_rdy(dout_rdy), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .cur_ch(cur_ch), .proto_err(proto_err),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents seen by the arbiter, plus bench-forced stalls
  logic [17:0] fq0[$];
  logic [17:0] fq1[$];
  logic        stall0 = 1'b0;
  logic        stall1 = 1'b0;
  logic        rdy_v = 1'b1;

  // Reference model: which channel holds the packet grant (-1 none) and expected outputs
  int          m_gnt;
  logic        m_last;
  logic        m_cur;
  logic        m_first;
  logic [15:0] m_cnt0, m_cnt1;
  logic [15:0] e_dout;
  logic        e_vld, e_sop, e_eop, e_err;

  int sop_order[$];
  int err_pulses;
  int first_vld_ch;

  typedef struct {
    logic [17:0] q0;
    logic        e0;
    logic        a0;
    logic        rdy;
    logic        x_rd0;
    logic        x_rd1;
    logic        x_vld;
    logic        x_sop;
    logic        x_eop;
    logic [15:0] x_dout;
    logic [15:0] x_cnt0;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic has_pkt(input int ch);
    logic r;
    r = 1'b0;
    if (ch == 0) begin
      foreach (fq0[i]) if (fq0[i][16]) r = 1'b1;
    end else begin
      foreach (fq1[i]) if (fq1[i][16]) r = 1'b1;
    end
    return r;
  endfunction

  // bad: 0 clean, 1 first word lacks sop, 2 second word carries sop
  task automatic push_pkt(input int ch, input int len, input logic [7:0] tag, input int bad);
    logic [17:0] w;
    for (int i = 0; i < len; i++) begin
      w[17] = (i == 0);
      w[16] = (i == len - 1);
      w[15:0] = {tag, 8'(i)};
      if (bad == 1 && i == 0) w[17] = 1'b0;
      if (bad == 2 && i == 1) w[17] = 1'b1;
      if (ch == 0) fq0.push_back(w);
      else fq1.push_back(w);
    end
  endtask

  task automatic model_reset();
    m_gnt = -1; m_last = 1'b1; m_cur = 1'b0; m_first = 1'b0;
    m_cnt0 = '0; m_cnt1 = '0;
    e_dout = '0; e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
  endtask

  // Asynchronous reset from the middle of a cycle; outputs must clear before any clock edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", {dout, dout_vld, dout_sop, dout_eop, proto_err, cur_ch,
                        pkt_cnt0, pkt_cnt1, ch0_rdreq, ch1_rdreq}, 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of FIFO-driven operation checked against the model
  task automatic cycle();
    logic r0, r1, er0, er1, a0, a1;
    logic [17:0] w;
    ch0_empty     = (fq0.size() == 0) || stall0;
    ch0_q         = (fq0.size() != 0) ? fq0[0] : '0;
    ch0_pkt_avail = has_pkt(0);
    ch1_empty     = (fq1.size() == 0) || stall1;
    ch1_q         = (fq1.size() != 0) ? fq1[0] : '0;
    ch1_pkt_avail = has_pkt(1);
    dout_rdy      = rdy_v;
    a0 = ch0_pkt_avail;
    a1 = ch1_pkt_avail;
    #1;
    chk("out", {dout, dout_vld, dout_sop, dout_eop, proto_err, cur_ch},
               {e_dout, e_vld, e_sop, e_eop, e_err, m_cur});
    chk("cnt", {pkt_cnt0, pkt_cnt1}, {m_cnt0, m_cnt1});
    er0 = (m_gnt == 0) && rdy_v && !ch0_empty;
    er1 = (m_gnt == 1) && rdy_v && !ch1_empty;
    chk("rdreq", {ch0_rdreq, ch1_rdreq}, {er0, er1});
    if (dout_vld && dout_sop) sop_order.push_back(int'(cur_ch));
    if (dout_vld && proto_err) err_pulses++;
    if (dout_vld && first_vld_ch < 0) first_vld_ch = int'(cur_ch);
    r0 = ch0_rdreq;
    r1 = ch1_rdreq;
    @(posedge clk);
    if (m_gnt < 0) begin
      e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
      if (a0 && (!a1 || m_last)) begin
        m_gnt = 0; m_last = 0; m_cur = 0; m_first = 1;
      end else if (a1) begin
        m_gnt = 1; m_last = 1; m_cur = 1; m_first = 1;
      end
    end else if (er0 || er1) begin
      w = er0 ? fq0[0] : fq1[0];
      e_vld = 1; e_sop = w[17]; e_eop = w[16]; e_dout = w[15:0];
      e_err = m_first ? !w[17] : w[17];
      m_first = 0;
      if (w[16]) begin
        if (m_gnt == 0) m_cnt0 = m_cnt0 + 16'd1;
        else m_cnt1 = m_cnt1 + 16'd1;
        m_gnt = -1;
      end
    end else begin
      e_vld = 0; e_sop = 0; e_eop = 0; e_err = 0;
    end
    if (r0 && fq0.size() != 0) void'(fq0.pop_front());
    if (r1 && fq1.size() != 0) void'(fq1.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Single 3-word ch0 packet driven directly: inputs, then rdreq and registered outputs
    tbl[0] = '{18'h2_1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
    tbl[1] = '{18'h2_1111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
    tbl[2] = '{18'h0_2222, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1111, 16'd0};
    tbl[3] = '{18'h1_3333, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 16'd0};
    tbl[4] = '{18'h0_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3333, 16'd1};
    tbl[5] = '{18'h0_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333, 16'd1};

    model_reset();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      ch0_q = tbl[i].q0; ch0_empty = tbl[i].e0; ch0_pkt_avail = tbl[i].a0;
      ch1_q = '0; ch1_empty = 1'b1; ch1_pkt_avail = 1'b0;
      dout_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_rdreq", i), {ch0_rdreq, ch1_rdreq}, {tbl[i].x_rd0, tbl[i].x_rd1});
      chk($sformatf("tbl%0d_out", i), {dout_vld, dout_sop, dout_eop, dout},
          {tbl[i].x_vld, tbl[i].x_sop, tbl[i].x_eop, tbl[i].x_dout});
      chk($sformatf("tbl%0d_cnt", i), {pkt_cnt0, pkt_cnt1}, {tbl[i].x_cnt0, 16'd0});
      @(posedge clk);
      @(negedge clk);
    end

    // Both channels loaded from reset: strict alternation starting with ch0
    fq0.delete(); fq1.delete();
    push_pkt(0, 3, 8'h10, 0); push_pkt(0, 3, 8'h11, 0);
    push_pkt(1, 2, 8'h20, 0); push_pkt(1, 2, 8'h21, 0);
    do_reset();
    sop_order.delete();
    run(30);
    chk("order_len", sop_order.size(), 4);
    for (int i = 0; i < sop_order.size() && i < 4; i++)
      chk($sformatf("order%0d", i), sop_order[i], i % 2);

    // ch0 runs dry for 4 cycles mid-packet while ch1 waits with a full packet
    push_pkt(0, 5, 8'h30, 0); push_pkt(1, 2, 8'h40, 0);
    do_reset();
    run(3);
    stall0 = 1'b1; run(4); stall0 = 1'b0;
    run(20);

    // Downstream back-pressure for 3 cycles mid-packet
    push_pkt(0, 5, 8'h50, 0);
    do_reset();
    run(3);
    rdy_v = 1'b0; run(3); rdy_v = 1'b1;
    run(15);

    // Framing errors: missing sop at grant start, then a stray sop inside a packet
    push_pkt(0, 3, 8'h60, 1); push_pkt(0, 4, 8'h61, 2);
    do_reset();
    err_pulses = 0;
    run(20);
    chk("err_pulses", err_pulses, 2);

    // Reset in the middle of a ch0 packet; the leftover words go out first on ch0
    push_pkt(0, 4, 8'h70, 0); push_pkt(1, 2, 8'h80, 0);
    do_reset();
    run(4);
    do_reset();
    first_vld_ch = -1;
    run(20);
    chk("post_reset_ch", first_vld_ch, 0);

    // Randomized traffic, back-pressure and stalls
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        int ch;
        ch = int'($urandom_range(0, 1));
        if ((ch == 0 ? fq0.size() : fq1.size()) < 20)
          push_pkt(ch, int'($urandom_range(1, 5)), 8'($urandom),
                   ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      rdy_v  = ($urandom_range(0, 9) != 0);
      stall0 = ($urandom_range(0, 9) == 0);
      stall1 = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
